// File: rtl/arqt_led_ctrl_if.sv
// Avalon-MM slave bus bundle for the LED controller: word address, chip
// select, active-low write strobe, write data and zero-latency read data.
interface arqt_led_ctrl_if;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address,
    output chipselect,
    output write_n,
    output writedata,
    input  readdata
  );

  modport slave (
    input  address,
    input  chipselect,
    input  write_n,
    input  writedata,
    output readdata
  );
endinterface

// File: rtl/arqt_led_ctrl.sv
// LED output controller: DATA/MODE registers with atomic set/clear writes,
// per-LED blink driven by a down-counting prescaler, and a global PWM
// brightness gate. The LED drive is registered one cycle after the state.
module arqt_led_ctrl #(
  parameter int WIDTH = 8,
  parameter int DIV_W = 24
) (
  input  logic             clk,
  input  logic             reset,
  arqt_led_ctrl_if.slave   bus,
  output logic [WIDTH-1:0] out_port
);

  localparam logic [2:0] ADDR_DATA  = 3'd0;
  localparam logic [2:0] ADDR_MODE  = 3'd1;
  localparam logic [2:0] ADDR_SET   = 3'd2;
  localparam logic [2:0] ADDR_CLEAR = 3'd3;
  localparam logic [2:0] ADDR_DIV   = 3'd4;
  localparam logic [2:0] ADDR_DUTY  = 3'd5;

  logic [WIDTH-1:0] data_q, data_d;
  logic [WIDTH-1:0] mode_q, mode_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [7:0]       duty_q, duty_d;
  logic [DIV_W-1:0] presc_q, presc_d;
  logic             phase_q, phase_d;
  logic [7:0]       pwm_q, pwm_d;
  logic [WIDTH-1:0] out_q, out_d;

  logic             wr_en;
  logic             pwm_on;
  logic [31:0]      rdata;

  // Upper write-data bits beyond WIDTH/DIV_W are legitimately ignored.
  logic             unused_wdata;
  assign unused_wdata = ^bus.writedata;

  assign wr_en  = bus.chipselect && !bus.write_n;
  assign pwm_on = (duty_q == 8'hFF) || (pwm_q < duty_q);

  // Next-state for registers, blink prescaler, PWM counter and LED drive.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
    data_d  = data_q;
    mode_d  = mode_q;
    div_d   = div_q;
    duty_d  = duty_q;
    presc_d = presc_q;
    phase_d = phase_q;
    pwm_d   = pwm_q + 8'd1;
    out_d   = data_q & (~mode_q | {WIDTH{phase_q}}) & {WIDTH{pwm_on}};

    if (wr_en) begin
      case (bus.address)
        ADDR_DATA:  data_d = bus.writedata[WIDTH-1:0];
        ADDR_MODE:  mode_d = bus.writedata[WIDTH-1:0];
        ADDR_SET:   data_d = data_q | bus.writedata[WIDTH-1:0];
        ADDR_CLEAR: data_d = data_q & ~bus.writedata[WIDTH-1:0];
        ADDR_DIV:   div_d  = bus.writedata[DIV_W-1:0];
        ADDR_DUTY:  duty_d = bus.writedata[7:0];
        default:    ;
      endcase
    end

    // A BLINK_DIV write restarts the prescaler and leaves the phase alone.
    if (wr_en && bus.address == ADDR_DIV) begin
      presc_d = bus.writedata[DIV_W-1:0];
    end else if (presc_q == '0) begin
      presc_d = div_q;
      phase_d = ~phase_q;
    end else begin
      presc_d = presc_q - DIV_W'(1);
    end
  end

  // State update; synchronous reset wins over any write in the same cycle.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers sample together.
    if (reset) begin
      data_q  <= '0;
      mode_q  <= '0;
      div_q   <= '0;
      duty_q  <= 8'hFF;
      presc_q <= '0;
      phase_q <= 1'b0;
      pwm_q   <= 8'd0;
      out_q   <= '0;
    end else begin
      data_q  <= data_d;
      mode_q  <= mode_d;
      div_q   <= div_d;
      duty_q  <= duty_d;
      presc_q <= presc_d;
      phase_q <= phase_d;
      pwm_q   <= pwm_d;
      out_q   <= out_d;
    end
  end

  // Zero-latency read mux; chipselect is not needed for reads.
  always_comb begin
    rdata = '0;
    case (bus.address)
      ADDR_DATA, ADDR_SET, ADDR_CLEAR: rdata[WIDTH-1:0] = data_q;
      ADDR_MODE:                       rdata[WIDTH-1:0] = mode_q;
      ADDR_DIV:                        rdata[DIV_W-1:0] = div_q;
      ADDR_DUTY:                       rdata[7:0]       = duty_q;
      default:                         rdata            = '0;
    endcase
  end

  assign bus.readdata = rdata;
  assign out_port     = out_q;

endmodule

// File: doc/arqt_led_ctrl.md
# arqt_led_ctrl

Parametrised Avalon-MM LED output controller: next generation of the 4-bit LED PIO. It drives `WIDTH` LED lines and adds atomic set/clear writes, per-LED blink mode with a programmable prescaler, and a global PWM brightness duty. It sits on the Nios II system interconnect as an Avalon-MM slave with zero-wait writes and zero-latency reads, with `out_port` going to board LEDs.

## Interface
- `WIDTH`, 8: number of LED channels (1..32).
- `DIV_W`, 24: width of the blink prescaler and `BLINK_DIV` register (1..32).
- `clk` input 1: system clock; all state updates on rising edge.
- `reset` input 1: synchronous, active-high reset.
- `address` input 3: register word select.
- `chipselect` input 1: slave select.
- `write_n` input 1: active-low write strobe; a write occurs when `chipselect && !write_n`.
- `writedata` input 32: write data.
- `readdata` output 32: read data, combinational from `address`; upper unused bits are 0.
- `out_port` output WIDTH: registered LED drive.

## Operation
- Registers (word addresses):
  - 0 `DATA`: R/W, WIDTH bits.
  - 1 `MODE`: R/W, WIDTH bits; 1 = blink, 0 = static.
  - 2 `SET`: write-only; `DATA |= writedata[WIDTH-1:0]`; reads return `DATA`.
  - 3 `CLEAR`: write-only; `DATA &= ~writedata[WIDTH-1:0]`; reads return `DATA`.
  - 4 `BLINK_DIV`: R/W, DIV_W bits.
  - 5 `DUTY`: R/W, 8 bits.
  - 6, 7: reserved; writes are ignored and reads return 0.
- Reset values: DATA=0, MODE=0, BLINK_DIV=0, DUTY=8'hFF, prescaler=0, blink_phase=0, pwm_cnt=0, out_port=0.
- Blink prescaler:
  - Down-counter. Each cycle where prescaler==0: toggle `blink_phase` and reload with BLINK_DIV. Otherwise decrement.
  - Phase period is therefore (BLINK_DIV+1) cycles; BLINK_DIV=0 toggles every cycle.
  - A write to BLINK_DIV loads the prescaler with the new value in the same edge. `blink_phase` is unchanged.
- PWM:
  - `pwm_cnt` is an 8-bit free-running up-counter that wraps 255→0.
  - `pwm_on = (DUTY==8'hFF) | (pwm_cnt < DUTY)`.
  - DUTY=0 gives LEDs always off. DUTY=N (1..254) gives N cycles on per 256-cycle period.
- Per-channel drive: `next_out[i] = DATA[i] & (MODE[i] ? blink_phase : 1) & pwm_on`. `out_port <= next_out` every cycle.
- Only one register is written per cycle; no set/clear/data collisions are possible.
- Writes with chipselect low, or with write_n high, have no effect.
- Reset asserted mid-operation takes priority over any write in the same cycle. All state returns to its reset value at that edge.

## Timing
- Write accepted at edge N. The register holds the new value after edge N, and `readdata` reflects it in cycle N+1. `out_port` reflects it after edge N+1 (one-cycle output register).
- Reads: zero wait states, zero read latency. `readdata` is a pure function of `address` and the current register state; chipselect is ignored for reads.
- Blink: with BLINK_DIV=D written at edge N, the first phase toggle occurs at edge N+D+1, then every D+1 edges after that.
- PWM: `pwm_cnt` increments every cycle including during writes. Its count after reset release at edge R equals (cycles since R) mod 256.
- During `reset`, `out_port`=0 and `readdata` shows the reset register values.

## Test plan
- Reset then reads: after reset, read addresses 0..7 → 0, 0, 0, 0, 0, 8'hFF at address 5, 0, 0; `out_port`=0.
- Static write plus set/clear: write DATA=8'hA5, SET=8'h0A, then CLEAR=8'h81 → DATA reads 8'hAF then 8'h2E; `out_port`=8'h2E one cycle after the last write.
- Blink: DATA=8'hFF, MODE=8'h0F, BLINK_DIV=3 → `out_port[3:0]` toggles between 4'h0 and 4'hF every 4 cycles; `out_port[7:4]` stays 4'hF.
- PWM: DATA=8'h01, DUTY=64 → `out_port[0]` high for exactly 64 of every 256 cycles. DUTY=0 → always 0. DUTY=255 → always 1.
- Reserved and non-selected writes: write address 6 with 32'hFFFFFFFF, and write address 0 with chipselect=0 → no register or `out_port` change.
- Reset mid-operation: assert reset in the same cycle as a DATA=8'hFF write during blinking → all registers return to reset values; `out_port`=0 on the next edge; blink_phase=0.
